// File: rtl/rct_mem_pkg.sv
// Shared mem_if request/response layout, command/response codes and
// the m2w_bridge FSM state encodings.
package rct_mem_pkg;

  localparam int RCT_MEM_DATA_W = 32;
  localparam int CMD_W  = 3;
  localparam int TID_W  = 16;
  localparam int MASK_W = 4;
  localparam int REQ_W  = 87;
  localparam int RESP_W = 51;

  localparam logic [CMD_W-1:0] CMD_READ  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_WRITE = 3'd1;

  localparam logic [CMD_W-1:0] RSP_RD  = 3'd0;
  localparam logic [CMD_W-1:0] RSP_WR  = 3'd1;
  localparam logic [CMD_W-1:0] RSP_ERR = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUS  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Field order gives the bit offsets: cmd at the top, wdata at [31:0].
  typedef struct packed {
    logic [CMD_W-1:0]          cmd;
    logic [TID_W-1:0]          tid;
    logic [RCT_MEM_DATA_W-1:0] addr;
    logic [MASK_W-1:0]         mask;
    logic [RCT_MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [CMD_W-1:0]          code;
    logic [TID_W-1:0]          tid;
    logic [RCT_MEM_DATA_W-1:0] rdata;
  } mem_resp_t;

  function automatic logic cmd_is_bus(input logic [CMD_W-1:0] c);
    return (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

endpackage

// File: rtl/m2w_bridge_if.sv
// mem_if request/response plus Wishbone master signals of m2w_bridge.
// master = bridge side, slave = NoC port and Wishbone peripheral side.
interface m2w_bridge_if
  import rct_mem_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int BUS_MASK  = 4
);
  logic                 mem_if_req_valid;
  logic                 mem_if_req_ready;
  logic [REQ_W-1:0]     mem_if_req;
  logic                 mem_if_resp_valid;
  logic                 mem_if_resp_ready;
  logic [RESP_W-1:0]    mem_if_resp;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic [BUS_WIDTH-1:0] wb_addr_o;
  logic [BUS_WIDTH-1:0] wb_data_o;
  logic [BUS_MASK-1:0]  wb_sel_o;
  logic                 wb_ack_i;
  logic                 wb_err_i;
  logic [BUS_WIDTH-1:0] wb_data_i;

  modport master (
    input  mem_if_req_valid, mem_if_req,
    output mem_if_req_ready,
    output mem_if_resp_valid, mem_if_resp,
    input  mem_if_resp_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_addr_o, wb_data_o, wb_sel_o,
    input  wb_ack_i, wb_err_i, wb_data_i
  );

  modport slave (
    output mem_if_req_valid, mem_if_req,
    input  mem_if_req_ready,
    input  mem_if_resp_valid, mem_if_resp,
    output mem_if_resp_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_addr_o, wb_data_o, wb_sel_o,
    output wb_ack_i, wb_err_i, wb_data_i
  );

endinterface

// File: rtl/m2w_timeout_cnt.sv
// Wishbone wait-state counter; only compiled when M2W_TIMEOUT_EN is defined.
`ifdef M2W_TIMEOUT_EN
module m2w_timeout_cnt #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [W-1:0] cnt_d, cnt_q;

  assign expired_o = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (inc_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  std_dffr #(.W(W)) u_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (cnt_d),
    .q_o    (cnt_q)
  );

endmodule
`endif

// File: rtl/std_dffr.sv
// Generic register with asynchronous active-low reset to RST.
module std_dffr #(
  parameter int         W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) q_o <= RST;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/m2w_bridge.sv
// mem_if responder to Wishbone classic master, one transaction in flight.
// Define M2W_TIMEOUT_EN to abort Wishbone cycles after TIMEOUT_CYCLES.
module m2w_bridge
  import rct_mem_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int BUS_MASK       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk_i,
  input logic          rstn_i,
  m2w_bridge_if.master bus
);

  mem_req_t  req_in, req_d, req_q;
  mem_resp_t resp_d, resp_q;
  logic [1:0] st_d, st_q;
  logic [2:0] flg_d, flg_q;
  logic rdy_q, cyc_q, vld_q;
  logic timeout;

  assign req_in = mem_req_t'(bus.mem_if_req);

  always_comb begin
    st_d   = st_q;
    req_d  = req_q;
    resp_d = resp_q;
    unique case (1'b1)
      (st_q == ST_IDLE): begin
        if (bus.mem_if_req_valid && rdy_q) begin
          req_d = req_in;
          if (cmd_is_bus(req_in.cmd)) begin
            st_d = ST_BUS;
          end else begin
            st_d   = ST_RESP;
            resp_d = '{code: RSP_ERR, tid: req_in.tid, rdata: '0};
          end
        end
      end
      (st_q == ST_BUS): begin
        resp_d.tid = req_q.tid;
        // err beats ack; ack beats a coincident timeout
        if (bus.wb_err_i) begin
          st_d         = ST_RESP;
          resp_d.code  = RSP_ERR;
          resp_d.rdata = '0;
        end else if (bus.wb_ack_i) begin
          st_d = ST_RESP;
          if (req_q.cmd == CMD_WRITE) begin
            resp_d.code  = RSP_WR;
            resp_d.rdata = '0;
          end else begin
            resp_d.code  = RSP_RD;
            resp_d.rdata = bus.wb_data_i;
          end
        end else if (timeout) begin
          st_d         = ST_RESP;
          resp_d.code  = RSP_ERR;
          resp_d.rdata = '0;
        end
      end
      (st_q == ST_RESP): begin
        if (bus.mem_if_resp_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign flg_d = {st_d == ST_IDLE, st_d == ST_BUS, st_d == ST_RESP};
  assign {rdy_q, cyc_q, vld_q} = flg_q;

  std_dffr #(.W(2), .RST(ST_IDLE)) u_st (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (st_d),
    .q_o    (st_q)
  );

  std_dffr #(.W(REQ_W)) u_req (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (req_d),
    .q_o    (req_q)
  );

  std_dffr #(.W(RESP_W)) u_resp (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (resp_d),
    .q_o    (resp_q)
  );

  std_dffr #(.W(3)) u_flg (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (flg_d),
    .q_o    (flg_q)
  );

`ifdef M2W_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  m2w_timeout_cnt #(.W(TO_W), .LIMIT(TIMEOUT_CYCLES)) u_to (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (st_q != ST_BUS),
    .inc_i     ((st_q == ST_BUS) && !bus.wb_ack_i && !bus.wb_err_i),
    .expired_o (timeout)
  );
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYCLES == 0);
  assign timeout   = 1'b0;
`endif

  assign bus.mem_if_req_ready  = rdy_q;
  assign bus.mem_if_resp_valid = vld_q;
  assign bus.mem_if_resp       = resp_q;
  assign bus.wb_cyc_o          = cyc_q;
  assign bus.wb_stb_o          = cyc_q;
  assign bus.wb_we_o           = cyc_q && (req_q.cmd == CMD_WRITE);
  assign bus.wb_addr_o         = BUS_WIDTH'(req_q.addr);
  assign bus.wb_data_o         = BUS_WIDTH'(req_q.wdata);
  assign bus.wb_sel_o          = BUS_MASK'(req_q.mask);

endmodule
